// File: rtl/lcd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_engine
// Brief    : HD44780 init sequencer and timed 8-bit bus engine for {op,data}
//            commands accepted over an enb/rdy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_engine #(
  parameter int T_PWR  = 750000,
  parameter int T_AS   = 2,
  parameter int T_EN   = 12,
  parameter int T_CMD  = 2000,
  parameter int T_CLR  = 82000,
  parameter int T_WAIT = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [3:0] op,
  input  logic [7:0] data,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       rdy
);

  localparam logic [31:0] c_t_pwr  = 32'(T_PWR);
  localparam logic [31:0] c_t_as   = 32'(T_AS);
  localparam logic [31:0] c_t_en   = 32'(T_EN);
  localparam logic [31:0] c_t_cmd  = 32'(T_CMD);
  localparam logic [31:0] c_t_clr  = 32'(T_CLR);
  localparam logic [31:0] c_t_wait = 32'(T_WAIT);

  localparam logic [3:0] c_op_clear = 4'd0;
  localparam logic [3:0] c_op_write = 4'd1;
  localparam logic [3:0] c_op_setad = 4'd3;
  localparam logic [3:0] c_op_wait2 = 4'd4;

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_SETUP    = 3'd2,
    S_PULSE    = 3'd3,
    S_HOLD     = 3'd4,
    S_DELAY    = 3'd5,
    S_IDLE     = 3'd6
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [31:0] r_post, w_post_nxt;
  logic [1:0]  r_init_idx, w_init_idx_nxt;
  logic        r_init_busy, w_init_busy_nxt;
  logic        r_rs, w_rs_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_en, r_rdy;
  logic [6:0]  w_addr;
  logic [7:0]  w_init_byte;

  assign w_cnt_inc = r_cnt + 32'd1;

  // Linear cursor index to DDRAM address: line 2 starts at 0x40.
  always_comb begin
    w_addr = 7'd0;
    if (data < 8'd40)
      w_addr = data[6:0];
    else if (data < 8'd80)
      w_addr = 7'(data + 8'd24);
  end

  always_comb begin
    w_init_byte = 8'h01;
    case (r_init_idx)
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h0C;
      2'd2:    w_init_byte = 8'h06;
      default: w_init_byte = 8'h01;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_post_nxt      = r_post;
    w_init_idx_nxt  = r_init_idx;
    w_init_busy_nxt = r_init_busy;
    w_rs_nxt        = r_rs;
    w_data_nxt      = r_data;
    case (r_state)
      S_PWR_WAIT: begin
        if (w_cnt_inc >= c_t_pwr) begin
          w_state_nxt    = S_INIT;
          w_cnt_nxt      = 32'd0;
          w_init_idx_nxt = 2'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_INIT: begin
        w_rs_nxt    = 1'b0;
        w_data_nxt  = w_init_byte;
        w_post_nxt  = (r_init_idx == 2'd3) ? c_t_clr : c_t_cmd;
        w_cnt_nxt   = 32'd0;
        w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (w_cnt_inc >= c_t_as) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = 32'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_PULSE: begin
        if (w_cnt_inc >= c_t_en) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 32'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_DELAY;
        w_cnt_nxt   = 32'd0;
      end
      S_DELAY: begin
        // Occupies post+1 cycles; the extra cycle is the return-to-idle slot.
        if (r_cnt >= r_post) begin
          w_cnt_nxt = 32'd0;
          if (!r_init_busy) begin
            w_state_nxt = S_IDLE;
          end else if (r_init_idx == 2'd3) begin
            w_init_busy_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_init_idx_nxt = r_init_idx + 2'd1;
            w_state_nxt    = S_INIT;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_IDLE: begin
        // Being in IDLE at this edge means the entry edge has already passed.
        if (enb) begin
          w_cnt_nxt = 32'd0;
          case (op)
            c_op_clear: begin
              w_rs_nxt    = 1'b0;
              w_data_nxt  = 8'h01;
              w_post_nxt  = c_t_clr;
              w_state_nxt = S_SETUP;
            end
            c_op_write: begin
              w_rs_nxt    = 1'b1;
              w_data_nxt  = data;
              w_post_nxt  = c_t_cmd;
              w_state_nxt = S_SETUP;
            end
            c_op_setad: begin
              w_rs_nxt    = 1'b0;
              w_data_nxt  = {1'b1, w_addr};
              w_post_nxt  = c_t_cmd;
              w_state_nxt = S_SETUP;
            end
            c_op_wait2: begin
              // HOLD keeps EN low and the bus untouched, giving the same
              // accept-to-idle framing as a bus command without a strobe.
              w_post_nxt  = c_t_wait;
              w_state_nxt = S_HOLD;
            end
            default: begin
              w_post_nxt  = 32'd1;
              w_state_nxt = S_DELAY;
            end
          endcase
        end
      end
      default: begin
        w_state_nxt = S_PWR_WAIT;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_PWR_WAIT;
      r_cnt       <= 32'd0;
      r_post      <= 32'd0;
      r_init_idx  <= 2'd0;
      r_init_busy <= 1'b1;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_en        <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_post      <= w_post_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_init_busy <= w_init_busy_nxt;
      r_rs        <= w_rs_nxt;
      r_data      <= w_data_nxt;
      r_en        <= (w_state_nxt == S_PULSE);
      r_rdy       <= (w_state_nxt == S_IDLE);
    end
  end

  assign LCD_RS   = r_rs;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = r_en;
  assign LCD_DATA = r_data;
  assign rdy      = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_cmd_engine
// Brief    : Self-checking bench for lcd_cmd_engine with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_engine;
  localparam int T_PWR  = 20;
  localparam int T_AS   = 1;
  localparam int T_EN   = 3;
  localparam int T_CMD  = 5;
  localparam int T_CLR  = 12;
  localparam int T_WAIT = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic [3:0] op = 4'd0;
  logic [7:0] data = 8'd0;
  logic       lcd_rs, lcd_rw, lcd_en, rdy;
  logic [7:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  lcd_cmd_engine #(
    .T_PWR(T_PWR), .T_AS(T_AS), .T_EN(T_EN),
    .T_CMD(T_CMD), .T_CLR(T_CLR), .T_WAIT(T_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .op(op), .data(data),
    .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .LCD_DATA(lcd_data), .rdy(rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bus monitor: one queue entry per EN strobe (RS, DATA at rise, width).
  bit         q_rs[$];
  logic [7:0] q_data[$];
  int         q_w[$];
  bit         mon_prev = 0;
  bit         cap_rs = 0;
  logic [7:0] cap_data = 8'd0;
  int         cap_w = 0;
  int         last_fall = 0;
  bit         stab_bad = 0;
  bit         rw_bad = 0;

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad = 1;
    if (!rst) begin
      mon_prev = 0;
      cap_w = 0;
    end else begin
      if (lcd_en === 1'b1 && !mon_prev) begin
        cap_rs = lcd_rs;
        cap_data = lcd_data;
        cap_w = 1;
      end else if (lcd_en === 1'b1) begin
        cap_w++;
        if (lcd_rs !== cap_rs || lcd_data !== cap_data) stab_bad = 1;
      end else if (mon_prev) begin
        q_rs.push_back(cap_rs);
        q_data.push_back(cap_data);
        q_w.push_back(cap_w);
        last_fall = cyc;
      end
      mon_prev = (lcd_en === 1'b1);
    end
  end

  // Reference: what one command should do on the bus and how long rdy drops.
  function automatic void model(input logic [3:0] m_op, input logic [7:0] m_data,
                                output bit bus, output bit rs,
                                output logic [7:0] b, output int low);
    int post;
    int d;
    bus = 0; rs = 0; b = 8'h00; post = 0;
    d = int'(m_data);
    case (m_op)
      4'd0: begin bus = 1; b = 8'h01; post = T_CLR; end
      4'd1: begin bus = 1; rs = 1; b = m_data; post = T_CMD; end
      4'd3: begin
        bus = 1; post = T_CMD;
        if (d < 40) b = 8'(128 + d);
        else if (d < 80) b = 8'(128 + d + 24);
        else b = 8'h80;
      end
      default: ;
    endcase
    if (bus) low = T_AS + T_EN + 1 + post + 1;
    else if (m_op == 4'd4) low = T_WAIT + 2;
    else low = 2;
  endfunction

  task automatic flush_mon();
    q_rs.delete();
    q_data.delete();
    q_w.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_rs, lcd_rw, lcd_en, lcd_data, rdy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got rs=%b rw=%b en=%b data=%h rdy=%b want all 0",
               lcd_rs, lcd_rw, lcd_en, lcd_data, rdy);
    end
  endtask

  task automatic test_init(input string tag);
    int n;
    int rdy_cyc;
    bit held;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h38; exp_b[1] = 8'h0C; exp_b[2] = 8'h06; exp_b[3] = 8'h01;
    flush_mon();
    enb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (lcd_en === 1'b1) break;
      n++;
    end while (n < 200);
    checks++;
    if (n < T_PWR || n >= 200) begin
      failures++;
      $display("FAIL %s_pwr_wait: EN low for %0d cycles, want >= %0d", tag, n, T_PWR);
    end
    n = 0;
    while (rdy !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    rdy_cyc = cyc;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_rdy_timeout: rdy=%b want 1", tag, rdy);
    end
    checks++;
    if (q_data.size() != 4) begin
      failures++;
      $display("FAIL %s_pulse_count: got %0d want 4", tag, q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== exp_b[i] || q_rs[i] !== 1'b0 || q_w[i] != T_EN) begin
          failures++;
          $display("FAIL %s_init_%0d: got data=%h rs=%b w=%0d want data=%h rs=0 w=%0d",
                   tag, i, q_data[i], q_rs[i], q_w[i], exp_b[i], T_EN);
        end
      end
    end
    checks++;
    if (rdy_cyc - last_fall != T_CLR + 2) begin
      failures++;
      $display("FAIL %s_clr_delay: fall-to-rdy %0d want %0d", tag, rdy_cyc - last_fall, T_CLR + 2);
    end
    held = 1;
    repeat (10) begin
      @(negedge clk);
      if (rdy !== 1'b1 || lcd_en !== 1'b0) held = 0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL %s_idle_hold: rdy/EN changed with enb=0, got rdy=%b want 1", tag, rdy);
    end
  endtask

  task automatic send_cmd(input logic [3:0] c_op, input logic [7:0] c_data, input string tag);
    bit bus, ers;
    logic [7:0] eb;
    int elow, low, n0, n;
    model(c_op, c_data, bus, ers, eb, elow);
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n0 = q_data.size();
    op = c_op;
    data = c_data;
    enb = 1'b1;
    low = 0;
    do begin
      @(negedge clk);
      if (low == 0) enb = 1'b0;
      if (rdy === 1'b1) break;
      low++;
    end while (low < 400);
    checks++;
    if (low != elow) begin
      failures++;
      $display("FAIL %s_rdy_low: op=%0d data=%h got %0d cycles want %0d", tag, c_op, c_data, low, elow);
    end
    checks++;
    if (q_data.size() - n0 != (bus ? 1 : 0)) begin
      failures++;
      $display("FAIL %s_pulses: op=%0d got %0d strobes want %0d", tag, c_op, q_data.size() - n0, bus ? 1 : 0);
    end else if (bus) begin
      checks++;
      if (q_data[n0] !== eb || q_rs[n0] !== ers || q_w[n0] != T_EN) begin
        failures++;
        $display("FAIL %s_bus: op=%0d data=%h got %h rs=%b w=%0d want %h rs=%b w=%0d",
                 tag, c_op, c_data, q_data[n0], q_rs[n0], q_w[n0], eb, ers, T_EN);
      end
    end
  endtask

  task automatic test_write();
    send_cmd(4'd1, 8'h57, "write");
  endtask

  task automatic test_setad();
    send_cmd(4'd3, 8'd43, "setad43");
    send_cmd(4'd3, 8'd4, "setad4");
    send_cmd(4'd3, 8'd90, "setad90");
    send_cmd(4'd3, 8'd79, "setad79");
    send_cmd(4'd3, 8'd40, "setad40");
  endtask

  task automatic test_wait_clear_nop();
    send_cmd(4'd4, 8'($urandom), "wait2");
    send_cmd(4'd0, 8'($urandom), "clear");
    send_cmd(4'd2, 8'($urandom), "nop");
  endtask

  task automatic test_random();
    logic [3:0] r_op;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: r_op = 4'd1;
        1: r_op = 4'd3;
        2: r_op = 4'd0;
        3: r_op = 4'd4;
        default: r_op = 4'($urandom_range(0, 15));
      endcase
      send_cmd(r_op, 8'($urandom), "random");
    end
  endtask

  task automatic test_stream();
    logic [3:0] s_op [22];
    logic [7:0] s_data [22];
    logic [7:0] e_b[$];
    bit e_rs[$];
    bit bus, rs;
    logic [7:0] b;
    int low, ptr, n;
    bit prev_rdy, done;
    s_op[0] = 4'd3; s_data[0] = 8'd0;
    for (int i = 1; i <= 8; i++) begin s_op[i] = 4'd1; s_data[i] = 8'($urandom_range(32, 126)); end
    s_op[9] = 4'd3; s_data[9] = 8'd40;
    for (int i = 10; i <= 19; i++) begin s_op[i] = 4'd1; s_data[i] = 8'($urandom_range(32, 126)); end
    s_op[20] = 4'd4; s_data[20] = 8'd0;
    s_op[21] = 4'd0; s_data[21] = 8'd0;
    for (int i = 0; i < 22; i++) begin
      model(s_op[i], s_data[i], bus, rs, b, low);
      if (bus) begin e_b.push_back(b); e_rs.push_back(rs); end
    end
    flush_mon();
    @(negedge clk);
    op = s_op[0]; data = s_data[0]; enb = 1'b1;
    ptr = 1; prev_rdy = 1; done = 0; n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (rdy === 1'b1 && !prev_rdy) begin
        if (ptr < 22) begin
          op = s_op[ptr]; data = s_data[ptr]; ptr++;
        end else begin
          enb = 1'b0;
          done = 1;
        end
      end
      prev_rdy = (rdy === 1'b1);
    end
    enb = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stream_timeout: ptr=%0d want 22 completed", ptr);
    end
    checks++;
    if (q_data.size() != e_b.size()) begin
      failures++;
      $display("FAIL stream_count: got %0d strobes want %0d", q_data.size(), e_b.size());
    end else begin
      for (int i = 0; i < e_b.size(); i++) begin
        checks++;
        if (q_data[i] !== e_b[i] || q_rs[i] !== e_rs[i]) begin
          failures++;
          $display("FAIL stream_byte_%0d: got %h rs=%b want %h rs=%b", i, q_data[i], q_rs[i], e_b[i], e_rs[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    op = 4'd1; data = 8'hA5; enb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (lcd_en === 1'b1) break;
      n++;
    end while (n < 20);
    enb = 1'b0;
    checks++;
    if (lcd_en !== 1'b1) begin
      failures++;
      $display("FAIL midrst_reach_pulse: EN=%b want 1", lcd_en);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({lcd_rs, lcd_en, lcd_data, rdy} !== 11'h000) begin
      failures++;
      $display("FAIL midrst_outputs: got rs=%b en=%b data=%h rdy=%b want all 0",
               lcd_rs, lcd_en, lcd_data, rdy);
    end
    repeat (2) @(negedge clk);
    test_init("reinit");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init("init");
    test_write();
    test_setad();
    test_wait_clear_nop();
    test_random();
    test_stream();
    test_reset_mid_pulse();
    checks++;
    if (rw_bad || stab_bad) begin
      failures++;
      $display("FAIL bus_integrity: rw_bad=%b stab_bad=%b want 0 0", rw_bad, stab_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_cmd_engine.md
Name: lcd_cmd_engine

Overview:
- Downstream stage of the LCD message sequencer. Accepts one {op, data} command at a time over an enb/rdy handshake.
- Runs the HD44780 power-on init sequence, then converts each command into a timed 8-bit parallel bus cycle on the character LCD pins (RS/RW/EN/DATA).
- rdy is the pacing signal: the sequencer advances its command pointer on each rising edge of rdy.

Parameters:
- T_PWR, 750000: power-on wait cycles before init (15 ms at 50 MHz).
- T_AS, 2: cycles RS/DATA are stable before EN rises.
- T_EN, 12: EN high width in cycles.
- T_CMD, 2000: post-cycle delay for ordinary commands and writes (40 us).
- T_CLR, 82000: post-cycle delay for clear display (1.64 ms).
- T_WAIT, 100000000: delay for the wait2 op (2 s).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- enb, in, 1: command stream enable; 0 means no further commands.
- op, in, 4: opcode. 0 = clear, 1 = write, 3 = setad, 4 = wait2.
- data, in, 8: character code (write) or linear cursor index (setad).
- LCD_RS, out, 1: register select (0 = instruction, 1 = data).
- LCD_RW, out, 1: read/write; always 0 (write only).
- LCD_EN, out, 1: enable strobe.
- LCD_DATA, out, 8: LCD data bus.
- rdy, out, 1: engine idle and able to accept a command.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Outputs: LCD_RS = 0, LCD_RW = 0, LCD_EN = 0, LCD_DATA = 0x00, rdy = 0.
  - State goes to PWR_WAIT; delay counter and init index clear.
  - Reset mid-cycle aborts immediately, EN drops, and the full power-on sequence restarts on release.
- States: PWR_WAIT, INIT, SETUP, PULSE, HOLD, DELAY, IDLE. All registered. The delay counter is 32-bit.
- PWR_WAIT: count T_PWR cycles, then go to INIT with index 0.
- INIT: issue four instruction cycles (RS = 0) in order, each followed by a T_CMD delay:
  - 0x38: 8-bit, 2 lines, 5x8 font.
  - 0x0C: display on, cursor off.
  - 0x06: increment, no shift.
  - 0x01: clear, with a T_CLR delay instead of T_CMD.
  - After the last delay, go to IDLE.
- Bus cycle:
  - SETUP: drive RS/DATA with EN = 0 for T_AS cycles.
  - PULSE: EN = 1 for exactly T_EN cycles.
  - HOLD: EN = 0 for 1 cycle, RS/DATA unchanged.
  - DELAY: wait for the command's post-delay.
  - RS/DATA hold their last values until the next SETUP.
- IDLE:
  - rdy = 1 only in IDLE. It rises on the edge that enters IDLE.
  - A command is accepted on any later edge in IDLE where enb = 1. It is never accepted on the entry edge, so the sequencer has one full cycle to update op/data after rdy rises.
  - On accept, op/data are latched and rdy = 0 from the next cycle.
- Op decode:
  - clear: RS = 0, DATA = 0x01, post-delay T_CLR.
  - write: RS = 1, DATA = data, post-delay T_CMD.
  - setad: RS = 0, DATA = 0x80 | addr, post-delay T_CMD. Address mapping:
    - data 0..39: addr = data.
    - data 40..79: addr = data + 24 (line 2 starts at 0x40).
    - data >= 80: addr = 0x00.
  - wait2: no bus cycle, EN stays 0, RS/DATA unchanged; DELAY for T_WAIT, then IDLE.
  - Any other op: NOP. DELAY of 1 cycle, then IDLE, so rdy pulses low for 2 cycles.
- Command latency: the accept edge to the IDLE re-entry edge is T_AS + T_EN + 1 + post-delay + 1 cycles.
- enb = 0 in IDLE: stay in IDLE with rdy held at 1. Commands are never queued. Input changes outside IDLE are ignored.
- LCD_RW is 0 at all times. Busy-flag polling is not used; all pacing is by counters.

Test Plan (T_PWR = 20, T_AS = 1, T_EN = 3, T_CMD = 5, T_CLR = 12, T_WAIT = 30):
- Release rst with enb = 0:
  - EN stays 0 for 20 cycles.
  - Then four EN pulses, each 3 cycles wide, with DATA 0x38, 0x0C, 0x06, 0x01 and RS = 0.
  - 5/5/5/12 cycle gaps after each HOLD.
  - rdy rises after the 0x01 delay and stays 1.
- After init, enb = 1, op = 1, data = 0x57:
  - One EN pulse with RS = 1, DATA = 0x57, EN high exactly 3 cycles.
  - rdy low for 1 + 3 + 1 + 5 + 1 cycles, then high.
- setad with data = 43 -> DATA = 0xC3, RS = 0. setad with data = 4 -> DATA = 0x84. setad with data = 90 -> DATA = 0x80.
- op = 4 (wait2) -> no EN activity, rdy low for 32 cycles. op = 0 (clear) -> DATA = 0x01, 12-cycle post-delay.
- Full sequencer stream (setad, 8 writes, setad, 10 writes, wait2, clear) driven by rdy rising edges -> LCD_DATA sequence matches byte for byte, with no command skipped or duplicated.
- Assert rst during the PULSE of a write -> EN = 0, rdy = 0, DATA = 0x00 immediately. After release, the full init sequence repeats.
